wired_bpu_upd_sched: RTL
========================

# wired_bpu_upd_sched

Update/redirect scheduler that sits directly in front of the `wired_pcgen` correction port. It has the only `bpu_correct_t` input to the predictor and shares it between three sources: one backend redirect source and two commit-stage training-update sources. It buffers updates so that they never collide with redirects. Optionally, after reset it scrubs the predictor's un-resettable branch-info RAM.

## Interface
Parameters:
- `QDEPTH`, default 4: update queue depth; power of two, ≥2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `redir_i`  in  `bpu_correct_t`: backend redirect; valid when `redir_i.redirect`=1; never back-pressured.
- `upd_valid_i`  in  2: commit update valid; port 0 is older.
- `upd_ready_o`  out  2: commit update ready.
- `upd_i`  in  `bpu_correct_t[1:0]`: commit update payload; its `redirect` field is ignored.
- `p_correct_o`  out  `bpu_correct_t`: registered correction to pcgen.
- `busy_o`  out  1: scrub in progress.

## Operation
- FSM states: `SCRUB` and `RUN`.
  - Reset enters `SCRUB` if `WIRED_BPU_SCRUB_EN` is defined, else `RUN`.
  - `SCRUB` → `RUN` in the cycle after scrub index 1023 is issued.
  - There is no other transition.
- Output selection each cycle, in priority order; the result is registered into `p_correct_o`:
  1. `redir_i.redirect`=1: `redir_i` is forwarded verbatim, including its `need_update`, `miss` and `ras_*` fields.
  2. State is `SCRUB`: the scrub record is issued and the index is incremented.
  3. Queue is non-empty: the head is issued with `redirect` forced to 0, and the head is popped.
  4. Otherwise: all-zero record (`redirect`=`need_update`=`miss`=`ras_miss_type`=0).
- Scrub record for index k (10-bit, 0..1023):
  - `pc` = `BPU_SCRUB_BASE` | (k<<2), giving `pc[11:3]`=k[9:1] and `pc[2]`=k[0]; `pc[14:12]`=0, so the info hash equals `pc[11:3]`.
  - `need_update`=1, `miss`=1.
  - `true_target_type`=`BPU_TARGET_NPC`, `true_conditional_jmp`=0, `true_taken`=0.
  - `history`=0, `ras_ptr`=0, `redirect`=0.
  - All other fields are 0.
- Queue:
  - Circular FIFO with `QDEPTH` entries; `count` is `$clog2(QDEPTH)+1` bits.
  - Up to 2 pushes and 1 pop per cycle.
- Ready rule (both terms use the registered `count`; no same-cycle pop bypass):
  - `upd_ready_o[0]` = `RUN` && (QDEPTH−count ≥ 1).
  - `upd_ready_o[1]` = `RUN` && (QDEPTH−count ≥ 2).
  - `upd_ready_o` does not depend on `upd_valid_i`.
- Push order:
  - If both ports are accepted in the same cycle, port 0 is written at `wptr` and port 1 at `wptr+1`.
  - If only port 1 is accepted, it is written at `wptr`.
- Pointers wrap modulo `QDEPTH`.
- Every accepted update is enqueued, including those with `need_update`=0.
- Redirects do not flush the queue; queued training data is committed state.
- A redirect during `SCRUB` stalls the scrub index for that cycle; no index is skipped.

## Timing
- Reset values:
  - `p_correct_o`=0, `count`=0, `rptr`=`wptr`=0, scrub index=0.
  - `busy_o`=1 with the macro, 0 without it.
  - `upd_ready_o`=00 with the macro; without it, 11 (the QDEPTH−count ≥ 1 and ≥ 2 terms both hold when the queue is empty).
- `busy_o` = (state==`SCRUB`), driven from the state register.
- Redirect latency: `redir_i` in cycle t appears on `p_correct_o` in cycle t+1.
- Update latency: an update handshaked in cycle t appears no earlier than t+2 (enqueue at edge t, pop in t+1, register at edge t+1). Each cycle in which a redirect wins adds one cycle.
- Throughput: one correction per cycle. Sustained two-port input is limited by the queue.
- Simultaneous events:
  - A push and a pop in the same cycle: `count` changes by (pushes−1).
  - Pushing into a slot freed by this cycle's pop is not allowed.
- Synchronous `rst` mid-operation discards queued entries (they are never emitted) and restarts the scrub at index 0.

## Configuration
- `WIRED_BPU_SCRUB_EN` defined:
  - `SCRUB` state, scrub counter and record generation are present.
  - 1024 scrub cycles run after every reset.
  - Updates are refused while scrubbing.
- `WIRED_BPU_SCRUB_EN` undefined:
  - The FSM is constant `RUN`; the counter is removed.
  - `busy_o` is tied to 0.
  - Output priority reduces to redirect > queue > zero.

## Structure
- Shared package / `wired0_defines.svh`:
  - `bpu_correct_t` and `bpu_target_type_e` (existing).
  - New constants `BPU_SCRUB_BASE` = 32'h1c000000 and `BPU_SCRUB_LEN` = 1024.
  - State enum `bpu_sched_state_e`.
- One sub-module, `wired_bpu_upd_fifo`:
  - Two-write/one-read circular FIFO parameterised by `QDEPTH`.
  - Exposes `count`, `head`, push and pop.
  - The arbiter, FSM and output register live in the top.

## Test plan
- Reset with the macro on:
  - `busy_o`=1 and `upd_ready_o`=00 for exactly 1024 cycles.
  - `p_correct_o.pc` steps 0x1c000000, 0x1c000004, …, 0x1c000ffc, with `miss`=`need_update`=1 and type NPC.
  - Then `busy_o`=0 and `upd_ready_o`=11.
- QDEPTH=4, empty queue; both ports valid with pc 0x1c000100 (port 0) and 0x1c000200 (port 1) in cycle t:
  - Both are accepted.
  - Output 0x1c000100 at t+2 and 0x1c000200 at t+3.
- Queue holds 2 entries; redirect (`true_target`=0x1c000800) in cycle t:
  - Redirect appears at t+1.
  - Queued entries appear at t+2 and t+3, in order.
- Fill the queue to 4 entries with no pops possible (redirect held high):
  - `upd_ready_o`=00.
  - At count 3, `upd_ready_o`=01.
  - At count 2, `upd_ready_o`=11.
- Redirect asserted while scrub index=100:
  - The redirect is emitted.
  - The next scrub record carries index 100 (pc 0x1c000190).
  - Total scrub records = 1024.
- `rst` with 3 queued entries:
  - Next cycle `p_correct_o`=0 and `count`=0.
  - None of the 3 entries is ever emitted.

Source files
------------

// File: rtl/wired_bpu_upd_sched_pkg.sv
// rtl/wired_bpu_upd_sched_pkg.sv - shared types and constants for the predictor update/redirect scheduler
// Purpose: the bpu_correct_t correction record, the target-type enum, the
//   scheduler FSM state enum, scrub constants and the scrub-record builder.
// Ports: none (package).
// Optional feature macro used by importers: WIRED_BPU_SCRUB_EN.
package wired_bpu_upd_sched_pkg;

  typedef enum logic [1:0] {
    BPU_TARGET_NPC    = 2'd0,
    BPU_TARGET_CALL   = 2'd1,
    BPU_TARGET_RETURN = 2'd2,
    BPU_TARGET_IMM    = 2'd3
  } bpu_target_type_e;

  typedef struct packed {
    logic             redirect;
    logic             need_update;
    logic             miss;
    logic [31:0]      pc;
    logic [31:0]      true_target;
    bpu_target_type_e true_target_type;
    logic             true_conditional_jmp;
    logic             true_taken;
    logic [5:0]       history;
    logic [3:0]       ras_ptr;
    logic [1:0]       ras_miss_type;
  } bpu_correct_t;

  typedef enum logic {
    SCHED_SCRUB = 1'b0,
    SCHED_RUN   = 1'b1
  } bpu_sched_state_e;

  localparam logic [31:0] BPU_SCRUB_BASE = 32'h1c000000;
  localparam int          BPU_SCRUB_LEN  = 1024;

  // Index k lands on pc[11:3]=k[9:1], pc[2]=k[0]; pc[14:12] stays 0 so the
  // info-RAM hash walks every row exactly once. A mispredicted NPC with no
  // taken/conditional bits makes the predictor write a clean entry.
  function automatic bpu_correct_t scrub_record(input logic [9:0] k);
    bpu_correct_t r;
    r                  = '0;
    r.pc               = BPU_SCRUB_BASE | {20'd0, k, 2'b00};
    r.need_update      = 1'b1;
    r.miss             = 1'b1;
    r.true_target_type = BPU_TARGET_NPC;
    return r;
  endfunction

endpackage

// File: rtl/wired_bpu_upd_fifo.sv
// rtl/wired_bpu_upd_fifo.sv - two-write/one-read circular FIFO of correction records
// Purpose: holds accepted commit updates until the scheduler output slot is free.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (clears pointers/count)
//   push[1:0]        : write enables; when both set, [0] goes first
//   push_data[1:0]   : records to write
//   pop              : consume head (caller guarantees count != 0)
//   head             : oldest record
//   count            : occupancy, $clog2(QDEPTH)+1 bits
// The caller guarantees pushes never exceed the free space seen at the start
// of the cycle; a same-cycle pop does not create room.
module wired_bpu_upd_fifo
  import wired_bpu_upd_sched_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                push,
  input  bpu_correct_t [1:0]        push_data,
  input  logic                      pop,
  output bpu_correct_t              head,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  bpu_correct_t  mem [QDEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_1;

  assign wptr_1 = wptr + PW'(1);
  assign head   = mem[rptr];

  // Storage is not reset: entries are only observed after a push.
  always_ff @(posedge clk) begin
    case (push)
      2'b11: begin
        mem[wptr]   <= push_data[0];
        mem[wptr_1] <= push_data[1];
      end
      2'b01:   mem[wptr] <= push_data[0];
      2'b10:   mem[wptr] <= push_data[1];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push[0]) + PW'(push[1]);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push[0]) + CW'(push[1]) - CW'(pop);
    end
  end

endmodule

// File: rtl/wired_bpu_upd_sched.sv
// rtl/wired_bpu_upd_sched.sv - arbitrates redirects, commit updates and RAM scrub onto the pcgen correction port
// Purpose: single owner of the predictor correction input. Priority each cycle:
//   redirect > scrub (SCRUB state only) > queued update > zero record.
//   Result is registered into p_correct_o.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   redir_i         : backend redirect (valid when .redirect), never stalled
//   upd_valid_i[1:0], upd_ready_o[1:0], upd_i[1:0] : commit updates, port 0 older
//   p_correct_o     : registered correction to pcgen
//   busy_o          : scrub in progress
// Macro WIRED_BPU_SCRUB_EN: when defined, 1024 scrub records are issued after
//   every reset and updates are refused meanwhile; otherwise FSM is fixed RUN.
module wired_bpu_upd_sched
  import wired_bpu_upd_sched_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  bpu_correct_t       redir_i,
  input  logic [1:0]         upd_valid_i,
  output logic [1:0]         upd_ready_o,
  input  bpu_correct_t [1:0] upd_i,
  output bpu_correct_t       p_correct_o,
  output logic               busy_o
);

  localparam int CW = $clog2(QDEPTH) + 1;

  bpu_sched_state_e state;
  logic [CW-1:0]    count;
  bpu_correct_t     head;
  logic [1:0]       accept;
  logic             pop;
  logic             run;
  bpu_correct_t     p_correct_nxt;

  // ---------------------------------------------------------------- FSM
`ifdef WIRED_BPU_SCRUB_EN
  bpu_sched_state_e state_nxt;
  logic [9:0]       scrub_idx;
  logic             scrub_issue;

  // A redirect steals the slot, so the index only advances when issued.
  assign scrub_issue = (state == SCHED_SCRUB) && !redir_i.redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCHED_SCRUB;
      scrub_idx <= '0;
    end else begin
      state <= state_nxt;
      if (scrub_issue) scrub_idx <= scrub_idx + 10'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (scrub_issue && (scrub_idx == 10'(BPU_SCRUB_LEN - 1))) state_nxt = SCHED_RUN;
  end
`else
  assign state = SCHED_RUN;
`endif

  // ------------------------------------------------------------- outputs
  assign run    = (state == SCHED_RUN);
  assign busy_o = (state == SCHED_SCRUB);

  // Ready is based only on registered occupancy; a pop this cycle does not
  // free a slot for this cycle's push.
  assign upd_ready_o[0] = run && (count <= CW'(QDEPTH - 1));
  assign upd_ready_o[1] = run && (count <= CW'(QDEPTH - 2));
  assign accept         = upd_valid_i & upd_ready_o;

  always_comb begin
    p_correct_nxt = '0;
    pop           = 1'b0;
    if (redir_i.redirect) begin
      p_correct_nxt = redir_i;
`ifdef WIRED_BPU_SCRUB_EN
    end else if (scrub_issue) begin
      p_correct_nxt = scrub_record(scrub_idx);
`endif
    end else if (count != '0) begin
      p_correct_nxt          = head;
      p_correct_nxt.redirect = 1'b0;
      pop                    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) p_correct_o <= '0;
    else     p_correct_o <= p_correct_nxt;
  end

  // ---------------------------------------------------------------- queue
  wired_bpu_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (upd_i),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule
